// File: rtl/reservation_station_multi_if.sv
// Issue, CDB broadcast and ALU dispatch bundle for reservation_station_multi.
// master = issue/CDB/ALU side driving the station, slave = the station itself.
interface reservation_station_multi_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              issue_en;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  tag_dest;
    logic [TAG_W-1:0]  tag_rs;
    logic              rs_ready;
    logic [DATA_W-1:0] val_rs;
    logic [TAG_W-1:0]  tag_rt;
    logic              rt_ready;
    logic [DATA_W-1:0] val_rt;
    logic              stall;
    logic [CNT_W-1:0]  occupancy;
    logic              alu_ready;
    logic              rs_valid_out;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [TAG_W-1:0]  alu_dest_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    modport master (
        output flush, issue_en, opcode, tag_dest, tag_rs, rs_ready, val_rs,
               tag_rt, rt_ready, val_rt, alu_ready, cdb_valid, cdb_tag, cdb_data,
        input  stall, occupancy, rs_valid_out, alu_opcode, alu_op1, alu_op2, alu_dest_tag
    );

    modport slave (
        input  flush, issue_en, opcode, tag_dest, tag_rs, rs_ready, val_rs,
               tag_rt, rt_ready, val_rt, alu_ready, cdb_valid, cdb_tag, cdb_data,
        output stall, occupancy, rs_valid_out, alu_opcode, alu_op1, alu_op2, alu_dest_tag
    );
endinterface

// File: rtl/reservation_station_multi.sv
// DEPTH-entry Tomasulo reservation station: issue with CDB bypass, CDB capture, flush, one dispatch/cycle.
// Optional RS_AGE_PRIORITY_EN: oldest-first dispatch via per-entry ages; otherwise lowest-index first.
module reservation_station_multi #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 6
) (
    input logic                         clk,
    input logic                         rst_n,
    reservation_station_multi_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  rj_r;
    logic [DEPTH-1:0]  rk_r;
    logic [OP_W-1:0]   op_r   [DEPTH];
    logic [TAG_W-1:0]  dest_r [DEPTH];
    logic [TAG_W-1:0]  qj_r   [DEPTH];
    logic [TAG_W-1:0]  qk_r   [DEPTH];
    logic [DATA_W-1:0] vj_r   [DEPTH];
    logic [DATA_W-1:0] vk_r   [DEPTH];
    logic [CNT_W-1:0]  occupancy_r;

    logic              stall_s;
    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              issue_accept_s;
    logic              issue_rj_s;
    logic              issue_rk_s;
    logic [DATA_W-1:0] issue_vj_s;
    logic [DATA_W-1:0] issue_vk_s;
    logic [DEPTH-1:0]  eligible_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              dispatch_valid_s;
    logic              transfer_s;

    // Stall looks only at registered occupancy, so a same-cycle dispatch never frees a slot for issue.
    assign stall_s        = (occupancy_r == CNT_W'(DEPTH));
    assign issue_accept_s = bus.issue_en && !stall_s && !bus.flush && free_found_s;

    // Issue-time bypass: an operand arriving not-ready but matching this cycle's broadcast is captured now.
    assign issue_rj_s = bus.rs_ready || (bus.cdb_valid && (bus.cdb_tag == bus.tag_rs));
    assign issue_rk_s = bus.rt_ready || (bus.cdb_valid && (bus.cdb_tag == bus.tag_rt));
    assign issue_vj_s = bus.rs_ready ? bus.val_rs : bus.cdb_data;
    assign issue_vk_s = bus.rt_ready ? bus.val_rt : bus.cdb_data;

    assign eligible_s       = busy_r & rj_r & rk_r;
    assign dispatch_valid_s = (|eligible_s) && !bus.flush;
    assign transfer_s       = dispatch_valid_s && bus.alu_ready;

    // Lowest-index free entry for the next issue.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s   = busy_r[i] ? free_idx_s : IDX_W'(i);
            free_found_s = free_found_s || !busy_r[i];
        end
    end

`ifdef RS_AGE_PRIORITY_EN
    logic [IDX_W-1:0] age_r [DEPTH];
    logic [IDX_W-1:0] issue_age_s;
    logic [IDX_W-1:0] best_age_s;
    logic             sel_found_s;

    // A new entry is the youngest: its age equals the number of entries left after this cycle's dispatch.
    assign issue_age_s = IDX_W'(occupancy_r - CNT_W'(transfer_s));

    // Oldest-first selection: the eligible entry with the smallest age.
    always_comb begin
        sel_idx_s   = '0;
        best_age_s  = '1;
        sel_found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic take_v;
            take_v      = eligible_s[i] && (!sel_found_s || (age_r[i] < best_age_s));
            sel_idx_s   = take_v ? IDX_W'(i) : sel_idx_s;
            best_age_s  = take_v ? age_r[i] : best_age_s;
            sel_found_s = sel_found_s || take_v;
        end
    end

    // Age bookkeeping: younger entries move up one rank when an older one leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= '0;
            end
        end else if (!bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_accept_s && (free_idx_s == IDX_W'(i))) begin
                    age_r[i] <= issue_age_s;
                end else if (transfer_s && busy_r[i] && (age_r[i] > age_r[sel_idx_s])) begin
                    age_r[i] <= age_r[i] - IDX_W'(1);
                end
            end
        end
    end
`else
    // Fixed priority: the lowest-index eligible entry wins.
    always_comb begin
        sel_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_idx_s = eligible_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end
`endif

    // Entry storage: flush squashes everything, otherwise dispatch clear, CDB capture and issue write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            rj_r   <= '0;
            rk_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]   <= '0;
                dest_r[i] <= '0;
                qj_r[i]   <= '0;
                qk_r[i]   <= '0;
                vj_r[i]   <= '0;
                vk_r[i]   <= '0;
            end
        end else if (bus.flush) begin
            busy_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (transfer_s && (sel_idx_s == IDX_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end
                if (busy_r[i] && !rj_r[i] && bus.cdb_valid && (qj_r[i] == bus.cdb_tag)) begin
                    rj_r[i] <= 1'b1;
                    vj_r[i] <= bus.cdb_data;
                end
                if (busy_r[i] && !rk_r[i] && bus.cdb_valid && (qk_r[i] == bus.cdb_tag)) begin
                    rk_r[i] <= 1'b1;
                    vk_r[i] <= bus.cdb_data;
                end
                if (issue_accept_s && (free_idx_s == IDX_W'(i))) begin
                    busy_r[i] <= 1'b1;
                    op_r[i]   <= bus.opcode;
                    dest_r[i] <= bus.tag_dest;
                    qj_r[i]   <= bus.tag_rs;
                    qk_r[i]   <= bus.tag_rt;
                    rj_r[i]   <= issue_rj_s;
                    rk_r[i]   <= issue_rk_s;
                    vj_r[i]   <= issue_vj_s;
                    vk_r[i]   <= issue_vk_s;
                end
            end
        end
    end

    // Busy entry count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_r <= '0;
        end else if (bus.flush) begin
            occupancy_r <= '0;
        end else begin
            occupancy_r <= occupancy_r + CNT_W'(issue_accept_s) - CNT_W'(transfer_s);
        end
    end

    assign bus.stall        = stall_s;
    assign bus.occupancy    = occupancy_r;
    assign bus.rs_valid_out = dispatch_valid_s;
    assign bus.alu_opcode   = dispatch_valid_s ? op_r[sel_idx_s]   : '0;
    assign bus.alu_op1      = dispatch_valid_s ? vj_r[sel_idx_s]   : '0;
    assign bus.alu_op2      = dispatch_valid_s ? vk_r[sel_idx_s]   : '0;
    assign bus.alu_dest_tag = dispatch_valid_s ? dest_r[sel_idx_s] : '0;
endmodule

// File: tb/tb_reservation_station_multi.sv
// Self-checking bench for reservation_station_multi: vector table, directed corner sequences,
// and randomized traffic against a slot/sequence-number reference model.
module tb_reservation_station_multi;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 6;
    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;
`ifdef RS_AGE_PRIORITY_EN
    localparam bit AGE_MODE = 1'b1;
`else
    localparam bit AGE_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reservation_station_multi_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();
    reservation_station_multi #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    typedef struct {
        logic        flush, iss;
        logic [5:0]  op;
        logic [4:0]  dest, trs;
        logic        rsr;
        logic [31:0] vrs;
        logic [4:0]  trt;
        logic        rtr;
        logic [31:0] vrt;
        logic        ardy, cv;
        logic [4:0]  ctag;
        logic [31:0] cdata;
        logic        e_stall;
        logic [2:0]  e_occ;
        logic        e_valid;
        logic [5:0]  e_op;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_dest;
    } vec_t;

    typedef struct {
        bit          busy, rj, rk;
        logic [5:0]  op;
        logic [4:0]  dest, qj, qk;
        logic [31:0] vj, vk;
        int unsigned seq;
    } slot_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t  vecs[$];
    slot_t m[DEPTH];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic st, logic [2:0] occ, logic v, logic [5:0] op,
                              logic [31:0] o1, logic [31:0] o2, logic [4:0] d);
        check({tag, ".stall"},     64'(bus.stall),        64'(st));
        check({tag, ".occupancy"}, 64'(bus.occupancy),    64'(occ));
        check({tag, ".valid"},     64'(bus.rs_valid_out), 64'(v));
        check({tag, ".opcode"},    64'(bus.alu_opcode),   64'(op));
        check({tag, ".op1"},       64'(bus.alu_op1),      64'(o1));
        check({tag, ".op2"},       64'(bus.alu_op2),      64'(o2));
        check({tag, ".dest"},      64'(bus.alu_dest_tag), 64'(d));
    endtask

    function automatic vec_t mk(logic fl, logic is, logic [5:0] op, logic [4:0] d,
                                logic rsr, logic [4:0] trs, logic [31:0] vrs,
                                logic rtr, logic [4:0] trt, logic [31:0] vrt,
                                logic ar, logic cv, logic [4:0] ct, logic [31:0] cd,
                                logic es, logic [2:0] eo, logic ev, logic [5:0] eop,
                                logic [31:0] e1, logic [31:0] e2, logic [4:0] ed);
        vec_t v;
        v.flush = fl; v.iss = is; v.op = op; v.dest = d;
        v.rsr = rsr; v.trs = trs; v.vrs = vrs; v.rtr = rtr; v.trt = trt; v.vrt = vrt;
        v.ardy = ar; v.cv = cv; v.ctag = ct; v.cdata = cd;
        v.e_stall = es; v.e_occ = eo; v.e_valid = ev; v.e_op = eop;
        v.e_op1 = e1; v.e_op2 = e2; v.e_dest = ed;
        return v;
    endfunction

    task automatic apply(vec_t v);
        bus.flush = v.flush; bus.issue_en = v.iss; bus.opcode = v.op; bus.tag_dest = v.dest;
        bus.rs_ready = v.rsr; bus.tag_rs = v.trs; bus.val_rs = v.vrs;
        bus.rt_ready = v.rtr; bus.tag_rt = v.trt; bus.val_rt = v.vrt;
        bus.alu_ready = v.ardy; bus.cdb_valid = v.cv; bus.cdb_tag = v.ctag; bus.cdb_data = v.cdata;
    endtask

    task automatic idle();
        apply(mk(L0, L0, 6'h0, 5'd0, L0, 5'd0, 32'd0, L0, 5'd0, 32'd0, L0, L0, 5'd0, 32'd0,
                 L0, 3'd0, L0, 6'h0, 32'd0, 32'd0, 5'd0));
    endtask

    task automatic issue(logic [5:0] op, logic [4:0] d, logic rsr, logic [4:0] trs, logic [31:0] vrs,
                         logic rtr, logic [4:0] trt, logic [31:0] vrt);
        bus.issue_en = 1'b1; bus.opcode = op; bus.tag_dest = d;
        bus.rs_ready = rsr; bus.tag_rs = trs; bus.val_rs = vrs;
        bus.rt_ready = rtr; bus.tag_rt = trt; bus.val_rt = vrt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0;
        idle();
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
    endtask

    // One randomized cycle: predict outputs from the model, compare, then advance the model.
    task automatic random_cycle(ref int unsigned next_seq);
        int occ, sel, free;
        logic v;
        bus.flush     = ($urandom_range(0, 99) < 3);
        bus.issue_en  = ($urandom_range(0, 99) < 60);
        bus.opcode    = 6'($urandom);
        bus.tag_dest  = 5'($urandom);
        bus.rs_ready  = $urandom_range(0, 1) == 1;
        bus.tag_rs    = 5'($urandom_range(0, 3));
        bus.val_rs    = $urandom;
        bus.rt_ready  = $urandom_range(0, 1) == 1;
        bus.tag_rt    = 5'($urandom_range(0, 3));
        bus.val_rt    = $urandom;
        bus.alu_ready = ($urandom_range(0, 99) < 70);
        bus.cdb_valid = $urandom_range(0, 1) == 1;
        bus.cdb_tag   = 5'($urandom_range(0, 3));
        bus.cdb_data  = $urandom;
        @(negedge clk);
        occ = 0; sel = -1; free = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy) occ++;
            else if (free < 0) free = i;
            if (m[i].busy && m[i].rj && m[i].rk) begin
                if (sel < 0) sel = i;
                else if (AGE_MODE && (m[i].seq < m[sel].seq)) sel = i;
            end
        end
        v = (sel >= 0) && !bus.flush;
        if (v) check_outs("rand", occ == DEPTH, 3'(occ), 1'b1, m[sel].op, m[sel].vj, m[sel].vk, m[sel].dest);
        else   check_outs("rand", occ == DEPTH, 3'(occ), 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
        end else begin
            if (v && bus.alu_ready) m[sel].busy = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy && bus.cdb_valid && !m[i].rj && m[i].qj == bus.cdb_tag) begin
                    m[i].rj = 1'b1; m[i].vj = bus.cdb_data;
                end
                if (m[i].busy && bus.cdb_valid && !m[i].rk && m[i].qk == bus.cdb_tag) begin
                    m[i].rk = 1'b1; m[i].vk = bus.cdb_data;
                end
            end
            if (bus.issue_en && occ < DEPTH) begin
                m[free].busy = 1'b1; m[free].op = bus.opcode; m[free].dest = bus.tag_dest;
                m[free].qj = bus.tag_rs; m[free].qk = bus.tag_rt;
                m[free].rj = bus.rs_ready || (bus.cdb_valid && bus.cdb_tag == bus.tag_rs);
                m[free].rk = bus.rt_ready || (bus.cdb_valid && bus.cdb_tag == bus.tag_rt);
                m[free].vj = bus.rs_ready ? bus.val_rs : bus.cdb_data;
                m[free].vk = bus.rt_ready ? bus.val_rt : bus.cdb_data;
                m[free].seq = next_seq++;
            end
        end
        tick();
    endtask

    initial begin
        logic [4:0] order[4];
        int unsigned seq_ctr;
`ifdef RS_AGE_PRIORITY_EN
        order = '{5'd11, 5'd12, 5'd13, 5'd14};
`else
        order = '{5'd14, 5'd11, 5'd12, 5'd13};
`endif
        // flush iss op dest | rsr trs vrs | rtr trt vrt | ardy cv ctag cdata || stall occ valid op op1 op2 dest
        vecs.push_back(mk(L0,L1,6'h20,5'd3, L1,5'd0,32'd5, L1,5'd0,32'd7, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd1,L1,6'h20,32'd5,32'd7,5'd3));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h21,5'd4, L0,5'd9,32'd0, L1,5'd0,32'd2, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd1,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L1,5'd9,32'hDEAD,   L0,3'd1,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd1,L1,6'h21,32'hDEAD,32'd2,5'd4));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h22,5'd5, L0,5'd9,32'd0, L1,5'd0,32'd3, L1,L1,5'd9,32'hBEEF,   L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd1,L1,6'h22,32'hBEEF,32'd3,5'd5));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd6, L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L0,5'd0,32'd0,    L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd7, L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L0,5'd0,32'd0,    L0,3'd1,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd8, L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L0,5'd0,32'd0,    L0,3'd2,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd9, L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L0,5'd0,32'd0,    L0,3'd3,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd10,L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L0,5'd0,32'd0,    L1,3'd4,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd10,L0,5'd15,32'd0, L1,5'd0,32'h22, L0,L1,5'd15,32'h11,  L1,3'd4,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L1,6'h01,5'd10,L1,5'd0,32'd1,  L1,5'd0,32'd1,  L1,L0,5'd0,32'd0,    L1,3'd4,L1,6'h01,32'h11,32'h22,5'd6));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L0,L0,5'd0,32'd0,      L0,3'd3,L1,6'h01,32'h11,32'h22,5'd7));
        vecs.push_back(mk(L1,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd3,L0,6'h0,32'd0,32'd0,5'd0));
        vecs.push_back(mk(L0,L0,6'h0,5'd0,  L0,5'd0,32'd0, L0,5'd0,32'd0, L1,L0,5'd0,32'd0,      L0,3'd0,L0,6'h0,32'd0,32'd0,5'd0));

        // Reset state after a 10-cycle reset.
        rst_n = 1'b0;
        idle();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 1'b0, 3'd0, 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
        tick();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_occ, vecs[i].e_valid,
                       vecs[i].e_op, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_dest);
            tick();
        end

        // Dispatch order after refilling a freed low slot.
        idle();
        issue(6'h02, 5'd10, 1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
        tick();
        for (int d = 11; d <= 13; d++) begin
            issue(6'h03, 5'(d), 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'd1);
            tick();
        end
        idle();
        bus.alu_ready = 1'b1;
        @(negedge clk);
        check_outs("order.first", 1'b1, 3'd4, 1'b1, 6'h02, 32'd100, 32'd200, 5'd10);
        tick();
        idle();
        issue(6'h03, 5'd14, 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'd1);
        @(negedge clk);
        check("order.refill_occ", 64'(bus.occupancy), 64'(3'd3));
        check("order.refill_stall", 64'(bus.stall), 64'(1'b0));
        tick();
        idle();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd20; bus.cdb_data = 32'd55;
        @(negedge clk);
        check("order.waiting_valid", 64'(bus.rs_valid_out), 64'(1'b0));
        tick();
        idle();
        bus.alu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_outs($sformatf("order%0d", k), k == 0, 3'(4 - k), 1'b1, 6'h03, 32'd55, 32'd1, order[k]);
            tick();
        end
        @(negedge clk);
        check("order.drained", 64'(bus.occupancy), 64'(3'd0));
        tick();

        // Flush overrides issue, capture and dispatch.
        idle();
        for (int d = 1; d <= 3; d++) begin
            issue(6'h04, 5'(d), 1'b0, 5'd21, 32'd0, 1'b0, 5'd21, 32'd0);
            tick();
        end
        idle();
        bus.flush = 1'b1; bus.alu_ready = 1'b1;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd21; bus.cdb_data = 32'd9;
        issue(6'h05, 5'd7, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
        @(negedge clk);
        check_outs("flush.cycle", 1'b0, 3'd3, 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
        tick();
        idle();
        bus.alu_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_outs("flush.after", 1'b0, 3'd0, 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
            tick();
        end

        // Asynchronous reset with a dispatch pending.
        idle();
        issue(6'h06, 5'd7, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4);
        tick();
        idle();
        @(negedge clk);
        check("rstmid.pending", 64'(bus.rs_valid_out), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check_outs("rstmid", 1'b0, 3'd0, 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("rstmid.after", 1'b0, 3'd0, 1'b0, 6'h0, 32'd0, 32'd0, 5'd0);
        tick();

        // Randomized traffic against the reference model.
        do_reset(2);
        seq_ctr = 0;
        for (int c = 0; c < 3000; c++) begin
            random_cycle(seq_ctr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
